// File: rtl/sram_responder.sv
// ============================================================================
// sram_responder
// ----------------------------------------------------------------------------
// Memory-side responder for the MEM stage of the pipeline. A 32-bit word read
// or write request is serviced against an external 16-bit asynchronous SRAM
// as two halfword accesses: the low half first, then the high half. Each
// halfword access (phase) lasts PHASE_CYCLES clock cycles. The top level
// freezes the pipeline while ready is low.
//
// Parameters
//   BASE_ADDR    : byte address that maps to SRAM halfword 0 (word 0)
//   SRAM_ADDR_W  : SRAM halfword address width
//   PHASE_CYCLES : clock cycles per halfword access (2..15)
//
// Ports
//   clk          : system clock, rising-edge
//   rst          : synchronous reset, active-low
//   mem_r_en     : read request from the MEM stage
//   mem_w_en     : write request from the MEM stage (wins over read)
//   address      : byte address of the request
//   write_data   : store value
//   read_data    : loaded word, valid in DONE after a read, held otherwise
//   ready        : combinational; 1 in DONE or in IDLE with no request
//   sram_addr    : SRAM halfword address
//   sram_dq_out  : write data towards the SRAM pins
//   sram_dq_in   : read data from the SRAM pins
//   sram_dq_oe   : 1 = drive sram_dq_out onto the data bus
//   sram_we_n    : SRAM write strobe, active-low
//
// Optional feature (macro SRAM_RESPONDER_STATS_EN)
//   rd_count     : number of completed reads, wraps at 16 bits
//   wr_count     : number of completed writes, wraps at 16 bits
// ============================================================================
module sram_responder #(
    parameter logic [31:0] BASE_ADDR    = 32'd1024,
    parameter int          SRAM_ADDR_W  = 18,
    parameter int          PHASE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_r_en,
    input  logic                   mem_w_en,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [15:0]            sram_dq_out,
    input  logic [15:0]            sram_dq_in,
    output logic                   sram_dq_oe,
    output logic                   sram_we_n
`ifdef SRAM_RESPONDER_STATS_EN
    ,
    output logic [15:0]            rd_count,
    output logic [15:0]            wr_count
`endif
);

    // Four bits cover the whole legal PHASE_CYCLES range of 2..15.
    localparam int             CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PHASE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_LO = 3'd1,
        RD_HI = 3'd2,
        WR_LO = 3'd3,
        WR_HI = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]            data_q, data_d;
    logic [31:0]            read_data_q, read_data_d;
    logic [SRAM_ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic [15:0]            sram_dq_out_q, sram_dq_out_d;
    logic                   sram_dq_oe_q, sram_dq_oe_d;
    logic                   sram_we_n_q, sram_we_n_d;

    logic [31:0]            off;
    logic [SRAM_ADDR_W-1:0] req_lo;
    logic                   cnt_last;

    // Halfword address of the low half: {off[31:2], 1'b0}, truncated so that
    // out-of-range addresses simply alias. Byte offset bits are dropped.
    assign off      = address - BASE_ADDR;
    assign req_lo   = SRAM_ADDR_W'((off >> 1) & 32'hFFFF_FFFE);
    assign cnt_last = (cnt_q == CNT_LAST);

    // Next-state logic: accept and latch a request in IDLE, then walk through
    // the low and high phases. Read data is sampled from the bus on the last
    // cycle of each read phase, when the SRAM output has had the full phase
    // to settle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        data_d      = data_q;
        read_data_d = read_data_q;

        case (state_q)
            IDLE: begin
                if (mem_w_en) begin
                    state_d = WR_LO;
                    cnt_d   = '0;
                    addr_d  = req_lo;
                    data_d  = write_data;
                end else if (mem_r_en) begin
                    state_d = RD_LO;
                    cnt_d   = '0;
                    addr_d  = req_lo;
                end
            end
            RD_LO, WR_LO: begin
                if (cnt_last) begin
                    state_d = (state_q == RD_LO) ? RD_HI : WR_HI;
                    cnt_d   = '0;
                    if (state_q == RD_LO) begin
                        read_data_d[15:0] = sram_dq_in;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RD_HI, WR_HI: begin
                if (cnt_last) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    if (state_q == RD_HI) begin
                        read_data_d[31:16] = sram_dq_in;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Pin outputs are registered, so they are computed from the state and
    // counter the FSM is about to enter. That keeps the address and data
    // stable for the whole phase and releases the write strobe on the final
    // cycle of each write phase to give the SRAM a data hold cycle.
    always_comb begin
        sram_addr_d   = sram_addr_q;
        sram_dq_out_d = sram_dq_out_q;
        sram_dq_oe_d  = 1'b0;
        sram_we_n_d   = 1'b1;

        case (state_d)
            RD_LO: begin
                sram_addr_d = addr_d;
            end
            RD_HI: begin
                sram_addr_d = addr_d | SRAM_ADDR_W'(1);
            end
            WR_LO: begin
                sram_addr_d   = addr_d;
                sram_dq_out_d = data_d[15:0];
                sram_dq_oe_d  = 1'b1;
                sram_we_n_d   = (cnt_d == CNT_LAST);
            end
            WR_HI: begin
                sram_addr_d   = addr_d | SRAM_ADDR_W'(1);
                sram_dq_out_d = data_d[31:16];
                sram_dq_oe_d  = 1'b1;
                sram_we_n_d   = (cnt_d == CNT_LAST);
            end
            default: begin
            end
        endcase
    end

    // State and output registers. Reset wins even in the middle of an
    // access; a partially written word is tolerated.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            addr_q        <= '0;
            data_q        <= '0;
            read_data_q   <= '0;
            sram_addr_q   <= '0;
            sram_dq_out_q <= '0;
            sram_dq_oe_q  <= 1'b0;
            sram_we_n_q   <= 1'b1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            read_data_q   <= read_data_d;
            sram_addr_q   <= sram_addr_d;
            sram_dq_out_q <= sram_dq_out_d;
            sram_dq_oe_q  <= sram_dq_oe_d;
            sram_we_n_q   <= sram_we_n_d;
        end
    end

    // ready is combinational so the pipeline freezes in the same cycle a
    // request shows up in IDLE.
    assign ready = (state_q == DONE) ||
                   ((state_q == IDLE) && !mem_r_en && !mem_w_en);

    assign read_data   = read_data_q;
    assign sram_addr   = sram_addr_q;
    assign sram_dq_out = sram_dq_out_q;
    assign sram_dq_oe  = sram_dq_oe_q;
    assign sram_we_n   = sram_we_n_q;

`ifdef SRAM_RESPONDER_STATS_EN
    logic [15:0] rd_count_q, rd_count_d;
    logic [15:0] wr_count_q, wr_count_d;

    // Transactions are counted on the step into DONE. A simultaneous
    // read+write request took the write path, so it only bumps wr_count.
    always_comb begin
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if ((state_q == RD_HI) && cnt_last) begin
            rd_count_d = rd_count_q + 16'd1;
        end
        if ((state_q == WR_HI) && cnt_last) begin
            wr_count_d = wr_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Testbench for sram_responder: table of directed word transactions with
// hand-computed SRAM addresses and read values, plus hand-written sequences
// for reset, mid-access reset and (optionally) the statistics counters.
module tb_sram_responder;

   localparam int PC = 2;

   logic        clk;
   logic        rst;
   logic        mem_r_en;
   logic        mem_w_en;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        ready;
   logic [17:0] sram_addr;
   logic [15:0] sram_dq_out;
   logic [15:0] sram_dq_in;
   logic        sram_dq_oe;
   logic        sram_we_n;
`ifdef SRAM_RESPONDER_STATS_EN
   logic [15:0] rd_count;
   logic [15:0] wr_count;
`endif

   int nChecks = 0;
   int nFails  = 0;

   typedef struct {
      logic        w;
      logic        r;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [17:0] expLo;
      logic [31:0] expRd;
   } vec_t;

   vec_t vecs [8];

   sram_responder #(
      .BASE_ADDR   (32'd1024),
      .SRAM_ADDR_W (18),
      .PHASE_CYCLES(PC)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .mem_r_en   (mem_r_en),
      .mem_w_en   (mem_w_en),
      .address    (address),
      .write_data (write_data),
      .read_data  (read_data),
      .ready      (ready),
      .sram_addr  (sram_addr),
      .sram_dq_out(sram_dq_out),
      .sram_dq_in (sram_dq_in),
      .sram_dq_oe (sram_dq_oe),
      .sram_we_n  (sram_we_n)
`ifdef SRAM_RESPONDER_STATS_EN
      ,
      .rd_count   (rd_count),
      .wr_count   (wr_count)
`endif
   );

   // Free-running 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Small asynchronous SRAM model: 64 halfwords, write while the strobe is
   // low and the bus is driven, read data follows the address.
   logic [15:0] sramMem [0:63];

   always @(posedge clk) begin
      if (!sram_we_n && sram_dq_oe) begin
         sramMem[sram_addr[5:0]] <= sram_dq_out;
      end
   end

   assign sram_dq_in = sram_dq_oe ? 16'h0000 : sramMem[sram_addr[5:0]];

   // Hard time limit so the run can never hang
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic vec_t mkVec(input logic w, input logic r, input logic [31:0] a,
                                  input logic [31:0] d, input logic [17:0] lo,
                                  input logic [31:0] rd);
      vec_t v;
      v.w     = w;
      v.r     = r;
      v.addr  = a;
      v.wdata = d;
      v.expLo = lo;
      v.expRd = rd;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Runs one word transaction starting in IDLE and checks every cycle up
   // to and including DONE, then steps back into IDLE. The request inputs
   // are scrambled after acceptance to show they were latched.
   task automatic applyStimulus(input int idx, input vec_t v);
      logic [17:0] expAddr;
      int          phase;
      int          cnt;
      mem_w_en   = v.w;
      mem_r_en   = v.r;
      address    = v.addr;
      write_data = v.wdata;
      #1;
      checkOutput($sformatf("v%0d idle_ready", idx), {31'd0, ready}, 32'd0);
      for (int k = 1; k <= 2 * PC + 1; k++) begin
         tick();
         if (k == 1) begin
            address    = ~v.addr;
            write_data = ~v.wdata;
         end
         if (k <= 2 * PC) begin
            phase   = (k - 1) / PC;
            cnt     = (k - 1) % PC;
            expAddr = v.expLo | 18'(phase);
            checkOutput($sformatf("v%0d c%0d sram_addr", idx, k), {14'd0, sram_addr}, {14'd0, expAddr});
            checkOutput($sformatf("v%0d c%0d dq_oe", idx, k), {31'd0, sram_dq_oe}, {31'd0, v.w});
            checkOutput($sformatf("v%0d c%0d we_n", idx, k), {31'd0, sram_we_n},
                        {31'd0, !(v.w && (cnt != PC - 1))});
            checkOutput($sformatf("v%0d c%0d ready", idx, k), {31'd0, ready}, 32'd0);
            if (v.w) begin
               checkOutput($sformatf("v%0d c%0d dq_out", idx, k), {16'd0, sram_dq_out},
                           {16'd0, (phase == 1) ? v.wdata[31:16] : v.wdata[15:0]});
            end
         end else begin
            checkOutput($sformatf("v%0d done_ready", idx), {31'd0, ready}, 32'd1);
            checkOutput($sformatf("v%0d read_data", idx), read_data, v.expRd);
         end
      end
      tick();
   endtask

   initial begin
      int expWr;
      int expRd;

      rst        = 1'b0;
      mem_r_en   = 1'b0;
      mem_w_en   = 1'b0;
      address    = '0;
      write_data = '0;
      for (int i = 0; i < 64; i++) sramMem[i] = 16'h0000;
      sramMem[10] = 16'h1234;
      sramMem[11] = 16'h5678;

      vecs[0] = mkVec(1'b1, 1'b0, 32'd1032,   32'hDEADBEEF, 18'h00004, 32'h00000000);
      vecs[1] = mkVec(1'b0, 1'b1, 32'd1033,   32'h00000000, 18'h00004, 32'hDEADBEEF);
      vecs[2] = mkVec(1'b1, 1'b1, 32'd1024,   32'h00000001, 18'h00000, 32'hDEADBEEF);
      vecs[3] = mkVec(1'b0, 1'b1, 32'd1024,   32'h00000000, 18'h00000, 32'h00000001);
      vecs[4] = mkVec(1'b0, 1'b1, 32'd1044,   32'h00000000, 18'h0000A, 32'h56781234);
      vecs[5] = mkVec(1'b1, 1'b0, 32'd1020,   32'hCAFEF00D, 18'h3FFFE, 32'h56781234);
      vecs[6] = mkVec(1'b0, 1'b1, 32'd1020,   32'h00000000, 18'h3FFFE, 32'hCAFEF00D);
      vecs[7] = mkVec(1'b0, 1'b1, 32'd525312, 32'h00000000, 18'h00000, 32'h00000001);

      // Reset held for two edges with a write request pending: no strobe
      mem_w_en   = 1'b1;
      address    = 32'd1032;
      write_data = 32'hDEADBEEF;
      for (int i = 0; i < 2; i++) begin
         tick();
         checkOutput($sformatf("reset%0d we_n", i), {31'd0, sram_we_n}, 32'd1);
         checkOutput($sformatf("reset%0d dq_oe", i), {31'd0, sram_dq_oe}, 32'd0);
      end
      checkOutput("reset read_data", read_data, 32'd0);
      checkOutput("reset sram_addr", {14'd0, sram_addr}, 32'd0);
      checkOutput("reset dq_out", {16'd0, sram_dq_out}, 32'd0);
      rst      = 1'b1;
      mem_w_en = 1'b0;
      #1;
      checkOutput("reset ready", {31'd0, ready}, 32'd1);
      tick();
      checkOutput("post_reset we_n", {31'd0, sram_we_n}, 32'd1);

      // Directed transaction table
      expWr = 0;
      expRd = 0;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(i, vecs[i]);
         if (vecs[i].w) expWr++;
         else if (vecs[i].r) expRd++;
      end
      mem_w_en = 1'b0;
      mem_r_en = 1'b0;
      #1;
      checkOutput("table_end ready", {31'd0, ready}, 32'd1);
      checkOutput("sram halfword0", {16'd0, sramMem[0]}, 32'h0001);
      checkOutput("sram halfword1", {16'd0, sramMem[1]}, 32'h0000);
`ifdef SRAM_RESPONDER_STATS_EN
      checkOutput("stats wr_count", {16'd0, wr_count}, 32'(expWr));
      checkOutput("stats rd_count", {16'd0, rd_count}, 32'(expRd));
`endif

      // Reset in the middle of WR_HI
      tick();
      mem_w_en   = 1'b1;
      address    = 32'd1032;
      write_data = 32'h11112222;
      tick();
      tick();
      tick();
      checkOutput("midrst in_wr_hi addr", {14'd0, sram_addr}, 32'd5);
      checkOutput("midrst in_wr_hi we_n", {31'd0, sram_we_n}, 32'd0);
      rst      = 1'b0;
      mem_w_en = 1'b0;
      tick();
      checkOutput("midrst we_n", {31'd0, sram_we_n}, 32'd1);
      checkOutput("midrst dq_oe", {31'd0, sram_dq_oe}, 32'd0);
      checkOutput("midrst sram_addr", {14'd0, sram_addr}, 32'd0);
      checkOutput("midrst read_data", read_data, 32'd0);
      checkOutput("midrst ready", {31'd0, ready}, 32'd1);
      rst = 1'b1;
      tick();
      checkOutput("midrst idle we_n", {31'd0, sram_we_n}, 32'd1);
      checkOutput("midrst idle ready", {31'd0, ready}, 32'd1);
`ifdef SRAM_RESPONDER_STATS_EN
      checkOutput("midrst wr_count", {16'd0, wr_count}, 32'd0);
`endif

      // Recovery read after the aborted write
      applyStimulus(8, mkVec(1'b0, 1'b1, 32'd1044, 32'h0, 18'h0000A, 32'h56781234));
      mem_r_en = 1'b0;
      #1;

`ifdef SRAM_RESPONDER_STATS_EN
      // Read counter wrap from a preset of 16'hFFFF
      force dut.rd_count_q = 16'hFFFF;
      #1;
      release dut.rd_count_q;
      tick();
      checkOutput("stats preset rd_count", {16'd0, rd_count}, 32'h0000FFFF);
      applyStimulus(9, mkVec(1'b0, 1'b1, 32'd1044, 32'h0, 18'h0000A, 32'h56781234));
      mem_r_en = 1'b0;
      #1;
      checkOutput("stats wrap rd_count", {16'd0, rd_count}, 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Memory-side responder for the pipeline's MEM stage. It accepts a 32-bit word read or write request and services it against an external 16-bit asynchronous SRAM as two halfword accesses.
- It returns a `ready` handshake; the top level drives the pipeline freeze from `~ready`.
- It replaces the single-cycle data memory. It sits between the EXE/MEM pipeline register outputs and the board SRAM pins.

Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM word 0.
- SRAM_ADDR_W, 18: SRAM halfword address width.
- PHASE_CYCLES, 2: clock cycles per halfword access; legal range 2..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-low (0 = reset), sampled on the rising edge of clk.
- mem_r_en  in  1  read request from the MEM stage.
- mem_w_en  in  1  write request from the MEM stage.
- address  in  32  byte address (ALU result).
- write_data  in  32  store value (Rm).
- read_data  out  32  loaded word; valid while ready=1 in DONE after a read.
- ready  out  1  request complete / no request pending.
- sram_addr  out  SRAM_ADDR_W  SRAM halfword address.
- sram_dq_out  out  16  write data to the SRAM pins.
- sram_dq_in  in  16  read data from the SRAM pins.
- sram_dq_oe  out  1  1 = drive sram_dq_out onto the bus.
- sram_we_n  out  1  SRAM write strobe, active-low.

Behaviour:
- Address mapping:
  - off = (address - BASE_ADDR), computed 32-bit, wrapping.
  - word = off[31:2]; off[1:0] are ignored.
  - Low half at sram_addr = {word, 1'b0} truncated to SRAM_ADDR_W; high half at the same address with bit 0 = 1.
  - Out-of-range addresses alias by truncation; no error is flagged.
- FSM states: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE. A phase counter cnt counts 0..PHASE_CYCLES-1 in each access state.
- IDLE:
  - mem_w_en=1 → WR_LO. Write has priority when mem_w_en and mem_r_en are both 1.
  - Otherwise mem_r_en=1 → RD_LO.
  - Otherwise stay in IDLE.
  - The request is latched (addr, data, type) on the transition; later input changes are ignored until DONE.
- Access states:
  - Each lasts exactly PHASE_CYCLES cycles.
  - Transitions: LO→HI, and HI→DONE when cnt = PHASE_CYCLES-1.
  - sram_addr is stable for the whole phase.
- Writes:
  - sram_dq_oe=1 throughout WR_LO/WR_HI.
  - sram_dq_out = data[15:0] in WR_LO, data[31:16] in WR_HI.
  - sram_we_n=0 for cnt < PHASE_CYCLES-1; sram_we_n=1 on the last cycle of each phase (data hold).
- Reads:
  - sram_dq_oe=0, sram_we_n=1.
  - sram_dq_in is captured into read_data[15:0] on the last cycle of RD_LO, and into read_data[31:16] on the last cycle of RD_HI.
- DONE:
  - Lasts exactly 1 cycle with ready=1, then → IDLE unconditionally.
  - A request present in that IDLE cycle is treated as a new request.
- ready is combinational:
  - 1 in DONE.
  - 1 in IDLE when mem_r_en=mem_w_en=0.
  - 0 otherwise, including IDLE with a request present.
- Latency: a request first seen in IDLE at cycle 0 yields ready=0 for cycles 0..2*PHASE_CYCLES and ready=1 at cycle 2*PHASE_CYCLES+1 (DONE).
- read_data holds its value until the next read capture. After a write, read_data retains the previous read value.
- Reset (rst=0 at an edge), effective even mid-access:
  - state=IDLE, cnt=0, read_data=0.
  - sram_we_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_out=0.
  - ready follows IDLE rules.
  - An in-flight write may be left partially done; this is acceptable.
- Outputs are registered except ready.

Optional Feature:
- Macro SRAM_RESPONDER_STATS_EN.
- When defined:
  - Adds output ports rd_count[15:0] and wr_count[15:0], reset to 0.
  - Each counter increments by 1 in the cycle the FSM enters DONE from RD_HI / WR_HI respectively.
  - Counters wrap 16'hFFFF→0.
  - A simultaneous read+write request counts as a write only.
- When undefined: the ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Reset: hold rst=0 for 2 cycles with mem_w_en=1 → ready=1, sram_we_n=1, sram_dq_oe=0, read_data=0, no strobe.
- Write:
  - Stimulus: address=1032, write_data=32'hDEADBEEF, PHASE_CYCLES=2.
  - Required: sram_addr=4 with dq 16'hBEEF, then sram_addr=5 with dq 16'hDEAD; sram_we_n low on the 1st cycle of each phase and high on the 2nd.
  - ready=0 for 5 cycles, then ready=1 for exactly 1 cycle.
- Read-back:
  - Stimulus: read address=1033 (low bits ignored) with the SRAM model preloaded with that data.
  - Required: read_data=32'hDEADBEEF in DONE; sram_dq_oe=0 throughout.
- Simultaneous request:
  - Stimulus: mem_r_en=mem_w_en=1, address=1024, data=32'h00000001.
  - Required: write performed to halfwords 0 and 1; read_data unchanged.
- Mid-access reset:
  - Stimulus: rst=0 during WR_HI.
  - Required: next cycle state IDLE, sram_we_n=1, sram_dq_oe=0. With requests deasserted, ready=1.
- Stats (SRAM_RESPONDER_STATS_EN):
  - Stimulus: 3 writes and 2 reads back-to-back.
  - Required: wr_count=3, rd_count=2. A preset of rd_count=16'hFFFF plus one read → 0.
